vc_arbiter: RTL

- Sequences four source virtual-channel FIFOs into two destination FIFOs for the PCIe switch datapath.
- Owns FIFO configuration: loads and holds the almost-full and almost-empty thresholds driven to every FIFO instance.
- Arbitrates source pops round-robin and routes each popped word to a destination by its MSB.
- Honours destination back-pressure (fifo_pause) and traps any FIFO error in a sticky error state.

---
 rtl/vc_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vc_arbiter.sv
// vc_arbiter: round-robin sequencer from four source VC FIFOs into two destination FIFOs.
// Optional build macro ARB_PRIO_EN gives source 0 strict priority over a 3-way round-robin of sources 1-3.
module vc_arbiter #(
    parameter int DATA_SIZE = 10,
    parameter int MAIN_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic [MAIN_SIZE:0]     af_thr_in,
    input  logic [MAIN_SIZE:0]     ae_thr_in,
    input  logic [3:0]             src_empty,
    input  logic [4*DATA_SIZE-1:0] src_data,
    input  logic [1:0]             dst_pause,
    input  logic [5:0]             fifo_err,
    output logic [MAIN_SIZE:0]     af_thr,
    output logic [MAIN_SIZE:0]     ae_thr,
    output logic [3:0]             src_pop,
    output logic [1:0]             dst_push,
    output logic [DATA_SIZE-1:0]   dst_data,
    output logic [4:0]             state,
    output logic                   idle,
    output logic                   error
);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [1:0]           rr_r;
    logic [1:0]           rr_next_s;
    logic [3:0]           pend_r;
    logic [3:0]           eligible_s;
    logic [3:0]           grant_s;
    logic [1:0]           cand_s;
    logic                 pop_ok_s;
    logic [DATA_SIZE-1:0] cap_word_s;
`ifdef ARB_PRIO_EN
    int                   base_s;
`endif

    assign state = state_r;

    // Next-state selection; an illegal encoding falls into the sticky error state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RESET: begin
                next_state_s = ST_INIT;
            end
            ST_INIT: begin
                if (init) next_state_s = ST_INIT;
                else      next_state_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (|fifo_err)                next_state_s = ST_ERROR;
                else if (init)                next_state_s = ST_INIT;
                else if (src_empty != 4'b1111) next_state_s = ST_ACTIVE;
                else                          next_state_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (|fifo_err) next_state_s = ST_ERROR;
                else if ((src_empty == 4'b1111) && (src_pop == 4'b0000) && (pend_r == 4'b0000))
                    next_state_s = ST_IDLE;
                else
                    next_state_s = ST_ACTIVE;
            end
            ST_ERROR: begin
                next_state_s = ST_ERROR;
            end
            default: begin
                next_state_s = ST_ERROR;
            end
        endcase
    end

    // A source just popped still shows its stale empty flag, so it sits out one cycle.
    assign eligible_s = ~src_empty & ~src_pop;
    assign pop_ok_s   = (state_r == ST_ACTIVE) && (next_state_s == ST_ACTIVE) && (dst_pause == 2'b00);

    // Grant selection: scan downwards so the candidate nearest rr_r is written last and wins.
    always_comb begin
        grant_s   = 4'b0000;
        rr_next_s = rr_r;
        cand_s    = 2'd0;
`ifdef ARB_PRIO_EN
        base_s = (rr_r == 2'd0) ? 0 : int'(rr_r) - 1;
        if (eligible_s[0]) begin
            grant_s = 4'b0001;
        end else begin
            for (int k = 2; k >= 0; k--) begin
                cand_s    = 2'(1 + ((base_s + k) % 3));
                grant_s   = eligible_s[cand_s] ? (4'b0001 << cand_s) : grant_s;
                rr_next_s = eligible_s[cand_s] ? ((cand_s == 2'd3) ? 2'd1 : cand_s + 2'd1) : rr_next_s;
            end
        end
`else
        for (int k = 3; k >= 0; k--) begin
            cand_s    = rr_r + 2'(k);
            grant_s   = eligible_s[cand_s] ? (4'b0001 << cand_s) : grant_s;
            rr_next_s = eligible_s[cand_s] ? cand_s + 2'd1 : rr_next_s;
        end
`endif
    end

    // Capture mux: pend_r is one-hot, so OR-ing the masked slices selects one word.
    always_comb begin
        cap_word_s = {DATA_SIZE{1'b0}};
        for (int i = 0; i < 4; i++) begin
            cap_word_s = cap_word_s | (src_data[i*DATA_SIZE +: DATA_SIZE] & {DATA_SIZE{pend_r[i]}});
        end
    end

    // State register and status flags, aligned with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RESET;
            idle    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            idle    <= (next_state_s == ST_IDLE);
            error   <= (next_state_s == ST_ERROR);
        end
    end

    // Threshold registers load only while INIT is requested.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            af_thr <= {(MAIN_SIZE+1){1'b0}};
            ae_thr <= {(MAIN_SIZE+1){1'b0}};
        end else if ((state_r == ST_INIT) && init) begin
            af_thr <= af_thr_in;
            ae_thr <= ae_thr_in;
        end else begin
            af_thr <= af_thr;
            ae_thr <= ae_thr;
        end
    end

    // Pop strobe and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_pop <= 4'b0000;
            rr_r    <= 2'd0;
        end else if (pop_ok_s) begin
            src_pop <= grant_s;
            rr_r    <= rr_next_s;
        end else begin
            src_pop <= 4'b0000;
            rr_r    <= rr_r;
        end
    end

    // Datapath: data arrives the cycle after the pop and is pushed the cycle after that.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r   <= 4'b0000;
            dst_push <= 2'b00;
            dst_data <= {DATA_SIZE{1'b0}};
        end else if (next_state_s == ST_ERROR) begin
            pend_r   <= 4'b0000;
            dst_push <= 2'b00;
            dst_data <= dst_data;
        end else begin
            pend_r <= src_pop;
            if (pend_r != 4'b0000) begin
                dst_push <= cap_word_s[DATA_SIZE-1] ? 2'b10 : 2'b01;
                dst_data <= cap_word_s;
            end else begin
                dst_push <= 2'b00;
                dst_data <= dst_data;
            end
        end
    end

endmodule
